loop_stride_addr_gen: RTL and testbench
=======================================

LOOP_STRIDE_ADDR_GEN -- requirements
Module: loop_stride_addr_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LOOP_ID_W, 5, loop-id width; up to 2^LOOP_ID_W nested loops.
- LOOP_ITER_W, 16, iteration-count width.
- ADDR_WIDTH, 8, address width.
- ADDR_STRIDE_W, ADDR_WIDTH, stride width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, reset: synchronous, active-high.
- start, in, 1, begin traversal.
- stall, in, 1, hold current address.
- base_addr, in, ADDR_WIDTH, start address; sampled on accepted start.
- cfg_loop_iter_v, in, 1, write iteration count.
- cfg_loop_iter, in, LOOP_ITER_W, iterations minus one.
- cfg_loop_iter_loop_id, in, LOOP_ID_W, target loop; 0 = outermost.
- cfg_addr_stride_v, in, 1, write stride.
- cfg_addr_stride, in, ADDR_STRIDE_W, stride value.
- addr_out, out, ADDR_WIDTH, current address.
- addr_out_valid, out, 1, addr_out valid.
- loop_index, out, LOOP_ID_W, outermost loop whose counter advances when the current address is accepted; 0 on the final address.
- loop_last_iter, out, 1, current address is the final one.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 Iteration table:
- cfg_loop_iter_v writes cfg_loop_iter to entry cfg_loop_iter_loop_id.
- num_loops SHALL become cfg_loop_iter_loop_id+1 on each write.
REQ-004 Stride table:
- cfg_addr_stride_v writes cfg_addr_stride to entry stride_ptr, then stride_ptr increments.
- Accepted start with no simultaneous stride write SHALL clear stride_ptr.
REQ-005 States SHALL be IDLE, BUSY and DONE.
REQ-006 IDLE: start SHALL capture base_addr and clear all loop indices.
- The next state SHALL be BUSY, or DONE if num_loops=0.
REQ-007 BUSY: addr_out_valid=1.
- addr_out SHALL equal base + sum over loops i<num_loops of idx_i*stride_i, modulo 2^ADDR_WIDTH.
REQ-008 Acceptance: the current address is accepted in a BUSY cycle with stall=0.
- On acceptance, the innermost loop (num_loops-1) increments.
- A loop at its configured maximum wraps to 0 and carries into the next-outer loop.
REQ-009 Accepting the address where every index is at its maximum (loop_last_iter=1) SHALL move the state to DONE.
REQ-010 DONE: done=1 and addr_out_valid=0 for exactly one cycle, then the state SHALL return to IDLE.
REQ-011 Stall:
- stall=1 holds all indices, addr_out and valid.
- stall has no effect in IDLE or DONE.
REQ-012 start SHALL be ignored in BUSY and DONE.
REQ-013 Latency: start at cycle t gives valid with addr_out=base_addr at t+1.
- No stall: one address per cycle, total count = product of (iter_i+1).
REQ-014 Configuration writes during BUSY SHALL take effect immediately; the behaviour is defined but not intended for use.
REQ-015 Arithmetic: all address sums wrap modulo 2^ADDR_WIDTH.
- Strides and iteration counts are unsigned.
REQ-016 Outputs SHALL be driven from registered state only; there is no combinational path from start or config inputs.

Reset
REQ-017 reset SHALL, at any time including mid-traversal, set:
- state to IDLE.
- addr_out_valid=0, done=0, addr_out=0, loop_index=0, loop_last_iter=0.
- all indices, stride_ptr, num_loops and both tables to 0.

Verification
REQ-018 iter[0]=1, iter[1]=2, strides 10,1, base 100, no stall -> addr 100,101,102,110,111,112; loop_index 1,1,0,1,1,0; last_iter on 112; done pulse next cycle.
REQ-019 Same config with stall=1 for 3 cycles while addr=101 -> 101 held valid 4 cycles; sequence otherwise unchanged.
REQ-020 One loop, iter=0, base 7 -> a single address 7 with loop_last_iter=1, then done.
REQ-021 ADDR_WIDTH=8, base 250, stride 3, iter=3 -> 250,253,0,3.
REQ-022 Reset mid-traversal -> valid=0 next cycle; then start without config -> done one cycle later, no valid address.
REQ-023 start pulsed while BUSY -> ignored; sequence and done timing unchanged.

Source files
------------

// File: rtl/loop_stride_addr_gen.sv
// loop_stride_addr_gen: nested-loop strided address generator.
// The address is recomputed every cycle from the registered indices, strides and base.
module loop_stride_addr_gen #(
    parameter int LOOP_ID_W     = 5,
    parameter int LOOP_ITER_W   = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int ADDR_STRIDE_W = ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
    input  logic [LOOP_ID_W-1:0]     cfg_loop_iter_loop_id,
    input  logic                     cfg_addr_stride_v,
    input  logic [ADDR_STRIDE_W-1:0] cfg_addr_stride,
    output logic [ADDR_WIDTH-1:0]    addr_out,
    output logic                     addr_out_valid,
    output logic [LOOP_ID_W-1:0]     loop_index,
    output logic                     loop_last_iter,
    output logic                     done
);
    localparam int N  = 2 ** LOOP_ID_W;
    localparam int PW = LOOP_ITER_W + ADDR_STRIDE_W;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                   state, state_n;
    logic [LOOP_ITER_W-1:0]   iter_q   [N];
    logic [ADDR_STRIDE_W-1:0] stride_q [N];
    logic [LOOP_ITER_W-1:0]   idx_q    [N];
    logic [LOOP_ITER_W-1:0]   idx_n    [N];
    logic [LOOP_ID_W:0]       num_loops;
    logic [LOOP_ID_W-1:0]     stride_ptr, adv_loop;
    logic [ADDR_WIDTH-1:0]    base_q, sum;
    logic [PW-1:0]            prod;
    logic                     carry, busy, accept, take_start;
    // Walk from the innermost active loop outward: carry marks that every inner loop is at max.
    always_comb begin
        sum      = base_q;
        carry    = 1'b1;
        adv_loop = '0;
        prod     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_n[i] = idx_q[i];
            if ((LOOP_ID_W + 1)'(i) < num_loops) begin
                prod = PW'(idx_q[i]) * PW'(stride_q[i]);
                sum  = sum + prod[ADDR_WIDTH-1:0];
                if (carry) begin
                    idx_n[i] = idx_q[i] >= iter_q[i] ? '0 : idx_q[i] + 1'b1;
                    adv_loop = idx_q[i] >= iter_q[i] ? adv_loop : LOOP_ID_W'(i);
                end
                carry = carry && idx_q[i] >= iter_q[i];
            end
        end
    end
    assign busy           = state == BUSY;
    assign accept         = busy && !stall;
    assign take_start     = state == IDLE && start;
    assign addr_out       = busy ? sum : '0;
    assign addr_out_valid = busy;
    assign loop_index     = busy ? adv_loop : '0;
    assign loop_last_iter = busy && carry;
    assign done           = state == DONE;
    always_comb begin
        state_n = state == IDLE ? (start ? (num_loops == '0 ? DONE : BUSY) : IDLE)
                : busy          ? (accept && carry ? DONE : BUSY)
                :                 IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            num_loops  <= '0;
            stride_ptr <= '0;
            iter_q     <= '{default: '0};
            stride_q   <= '{default: '0};
            idx_q      <= '{default: '0};
        end else begin
            state <= state_n;
            if (cfg_loop_iter_v) begin
                iter_q[cfg_loop_iter_loop_id] <= cfg_loop_iter;
                num_loops                     <= {1'b0, cfg_loop_iter_loop_id} + 1'b1;
            end
            if (cfg_addr_stride_v) begin
                stride_q[stride_ptr] <= cfg_addr_stride;
                stride_ptr           <= stride_ptr + 1'b1;
            end else if (take_start) begin
                stride_ptr <= '0;
            end
            if (take_start) begin
                base_q <= base_addr;
                idx_q  <= '{default: '0};
            end else if (accept) begin
                idx_q <= idx_n;
            end
        end
    end
endmodule

// File: tb/tb_loop_stride_addr_gen.sv
// tb_loop_stride_addr_gen: directed scenarios checked against a mixed-radix counting model.
module tb_loop_stride_addr_gen;
    logic        clk = 0, reset = 1, start = 0, stall = 0;
    logic [7:0]  base_addr = 0;
    logic        cfg_loop_iter_v = 0;
    logic [15:0] cfg_loop_iter = 0;
    logic [4:0]  cfg_loop_iter_loop_id = 0;
    logic        cfg_addr_stride_v = 0;
    logic [7:0]  cfg_addr_stride = 0;
    logic [7:0]  addr_out;
    logic        addr_out_valid;
    logic [4:0]  loop_index;
    logic        loop_last_iter, done;
    int errors = 0, checks = 0, done_cnt = 0, valid_cnt = 0;
    bit checking = 0, prev_last = 0;
    typedef struct {int a; int li; bit last;} exp_t;
    exp_t exp_q[$];
    int m_iter[8], m_stride[8], m_n, m_base;

    always #5 clk = ~clk;

    loop_stride_addr_gen dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .base_addr(base_addr),
        .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
        .cfg_loop_iter_loop_id(cfg_loop_iter_loop_id), .cfg_addr_stride_v(cfg_addr_stride_v),
        .cfg_addr_stride(cfg_addr_stride), .addr_out(addr_out), .addr_out_valid(addr_out_valid),
        .loop_index(loop_index), .loop_last_iter(loop_last_iter), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Address k is the k-th point of a mixed-radix count; the advancing loop is the outermost changed digit.
    function automatic void build();
        int total, r, r2, s;
        int d[8], d2[8];
        exp_t e;
        total = 1;
        exp_q.delete();
        for (int i = 0; i < m_n; i++) total *= m_iter[i] + 1;
        for (int k = 0; k < total; k++) begin
            r = k; r2 = k + 1; s = m_base;
            for (int i = m_n - 1; i >= 0; i--) begin
                d[i] = r % (m_iter[i] + 1);   r  /= m_iter[i] + 1;
                d2[i] = r2 % (m_iter[i] + 1); r2 /= m_iter[i] + 1;
            end
            for (int i = 0; i < m_n; i++) s += d[i] * m_stride[i];
            e.a = s % 256;
            e.last = k == total - 1;
            e.li = 0;
            if (!e.last)
                for (int i = m_n - 1; i >= 0; i--) if (d[i] != d2[i]) e.li = i;
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (checking && !reset) begin
            if (prev_last) chk("done_timing", done, 1);
            prev_last = 0;
            if (addr_out_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) chk("extra_valid", addr_out_valid, 0);
                else begin
                    chk("addr", addr_out, exp_q[0].a);
                    chk("loop_index", loop_index, exp_q[0].li);
                    chk("last_iter", loop_last_iter, exp_q[0].last);
                    prev_last = exp_q[0].last && !stall;
                    if (!stall) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                chk("done_no_valid", addr_out_valid, 0);
                chk("done_queue_empty", exp_q.size(), 0);
            end
        end
        if (done) done_cnt++;
    end

    task automatic configure(input int n, input int base);
        m_n = n;
        m_base = base;
        for (int i = 0; i < n; i++) begin
            cfg_loop_iter_v = 1;   cfg_loop_iter = 16'(m_iter[i]);   cfg_loop_iter_loop_id = 5'(i);
            cfg_addr_stride_v = 1; cfg_addr_stride = 8'(m_stride[i]);
            @(posedge clk); #1;
        end
        cfg_loop_iter_v = 0;
        cfg_addr_stride_v = 0;
        base_addr = 8'(base);
    endtask

    task automatic run(input int st_lo, input int st_hi, input int per, input bit mid_start, input int exp_valid);
        int cyc, d0, v0;
        cyc = 0; d0 = done_cnt; v0 = valid_cnt;
        build();
        checking = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("latency_valid", addr_out_valid, 1);
        chk("latency_addr", addr_out, m_base);
        while (done_cnt == d0 && cyc < 500) begin
            stall = (cyc >= st_lo && cyc <= st_hi) || (per > 0 && cyc % per == 1);
            start = mid_start && cyc == 2;
            @(posedge clk); #1;
            cyc++;
        end
        stall = 0;
        start = 0;
        checking = 0;
        chk("done_seen", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        if (exp_valid >= 0) chk("valid_cycles", valid_cnt - v0, exp_valid);
        chk("idle_valid", addr_out_valid, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", addr_out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_loop_index", loop_index, 0);
        chk("rst_last", loop_last_iter, 0);
        reset = 0;
        m_iter[0] = 1; m_iter[1] = 2; m_stride[0] = 10; m_stride[1] = 1;
        configure(2, 100);
        build();
        begin
            int pa[6] = '{100, 101, 102, 110, 111, 112};
            int pl[6] = '{1, 1, 0, 1, 1, 0};
            chk("model_len", exp_q.size(), 6);
            for (int i = 0; i < 6; i++) begin
                chk("model_addr", exp_q[i].a, pa[i]);
                chk("model_li", exp_q[i].li, pl[i]);
            end
            chk("model_last", exp_q[5].last, 1);
        end
        run(-1, -1, 0, 0, 6);
        run(1, 3, 0, 0, 9);
        run(-1, -1, 0, 1, 6);
        m_iter[0] = 0; m_stride[0] = 5;
        configure(1, 7);
        run(-1, -1, 0, 0, 1);
        m_iter[0] = 3; m_stride[0] = 3;
        configure(1, 250);
        build();
        chk("model_wrap2", exp_q[2].a, 0);
        chk("model_wrap3", exp_q[3].a, 3);
        run(-1, -1, 0, 0, 4);
        m_iter[0] = 2; m_iter[1] = 1; m_iter[2] = 3;
        m_stride[0] = 40; m_stride[1] = 7; m_stride[2] = 250;
        configure(3, 5);
        run(-1, -1, 3, 0, -1);
        m_iter[0] = 1; m_iter[1] = 2; m_stride[0] = 10; m_stride[1] = 1;
        configure(2, 100);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("midrst_valid", addr_out_valid, 0);
        chk("midrst_addr", addr_out, 0);
        chk("midrst_last", loop_last_iter, 0);
        chk("midrst_done", done, 0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("empty_done", done, 1);
        chk("empty_valid", addr_out_valid, 0);
        @(posedge clk); #1;
        chk("empty_done_drop", done, 0);
        chk("empty_valid_after", addr_out_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
